adder_tree_sequencer: RTL and testbench
=======================================

# adder_tree_sequencer

Sequencer that streams a multi-beat hypervector reduction through the 16-input, 4-stage `pipelined_adder_tree`. It accepts 16-lane beats over a valid/ready stream and drives the tree's `inputs`/`last_in`. It tracks each beat through the tree's fixed latency with a valid shift register and accumulates the tree outputs into a wider running sum. It returns one result per job over a valid/ready handshake, and sits between the HD encoder buffer and the similarity/classification stage.

## Interface
- `WIDTH`, 8: lane width; must match the tree's `INPUT_WIDTH`.
- `ACC_W`, 16: accumulator and result width; `ACC_W >= WIDTH`.
- `TREE_LAT`, 4: number of clock edges from presenting tree inputs to a valid `tree_out`.
- `CNT_W`, 8: width of the beat count.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: job request; sampled only in IDLE.
- `num_beats` in CNT_W: beats in the job; sampled with `start`.
- `bias` in WIDTH: added once per job through the tree's `last_in`; sampled with `start`.
- `busy` out 1: high in every state except IDLE.
- `in_valid` in 1: beat available.
- `in_data` in 16*WIDTH: 16 packed lanes, lane 0 in the LSBs.
- `in_ready` out 1: high only in FEED.
- `tree_inputs` out 16*WIDTH: drives the tree's `inputs`.
- `tree_last_in` out WIDTH: drives the tree's `last_in`.
- `tree_out` in WIDTH: the tree's `out`.
- `result` out ACC_W: job sum; stable while `result_valid` is high.
- `result_valid` out 1: high in DONE.
- `result_ready` in 1: result consumer handshake.

## Operation
- **States.** IDLE, FEED, DRAIN, DONE.
- **IDLE.**
  - `start` with `num_beats != 0`: latch count and bias, clear the accumulator, go to FEED.
  - `start` with `num_beats == 0`: clear the accumulator, go to DONE (result 0).
  - `start` outside IDLE is ignored.
- **FEED.**
  - A beat fires on `in_valid && in_ready`.
  - On fire: `tree_inputs = in_data` (combinational pass-through). `tree_last_in` is the latched bias on the first beat of the job and 0 on every later beat.
  - With no fire, both `tree_inputs` and `tree_last_in` are driven to 0, so bubbles contribute nothing.
  - The remaining-beat counter decrements on each fire. The fire that takes it to 0 moves the FSM to DRAIN.
- **Valid tracking.**
  - `vld_pipe[TREE_LAT-1:0]` shifts in the fire bit every cycle.
  - When `vld_pipe[TREE_LAT-1]` is high, `acc <= acc + zero_extend(tree_out)` at that edge.
- **DRAIN.**
  - `in_ready` = 0 and tree drives are 0.
  - Go to DONE at the edge where `vld_pipe[TREE_LAT-1]` is high and all other `vld_pipe` bits are 0; that edge also performs the final accumulate.
- **DONE.**
  - `result_valid` = 1 and `result = acc`.
  - On `result_ready`, go to IDLE; `result_valid` drops the next cycle.
- **Arithmetic.**
  - Each beat's tree sum (16 lanes plus `last_in`) wraps modulo 2^WIDTH inside the tree, and the sequencer does not correct this.
  - The accumulator wraps modulo 2^ACC_W.
- **Reset.**
  - Asynchronous reset, any time, forces IDLE and clears `vld_pipe`, counter, accumulator and latched bias.
  - Output reset values: `busy`=0, `in_ready`=0, `result_valid`=0, `result`=0, `tree_inputs`=0, `tree_last_in`=0.
  - The tree itself has no reset. Stale data still in its pipeline is ignored because `vld_pipe` is cleared.

## Timing
- `start` sampled at edge E0; FEED from cycle 1.
- With `in_valid` held high, beat k fires in cycle k (1..N).
  - DRAIN from cycle N+1.
  - `vld_pipe[3]` high in cycles 5..N+4.
  - Last accumulate at the end of cycle N+4.
  - `result_valid` high from cycle N+5: `start` to result is N+5 cycles.
- Each gap cycle (`in_valid` low in FEED) adds exactly one cycle to latency.
- `num_beats == 0`: `result_valid` in cycle 1.
- Throughput: one beat per cycle; one job in flight. The next `start` is accepted in the cycle after the result handshake.
- `result_ready` held low keeps DONE and `result` indefinitely.
- `result_ready` high in the first DONE cycle: `result_valid` is high for exactly 1 cycle.

## Test plan
- **Single beat.** N=1, `in_data` lanes 0..15, bias 3, `result_ready`=1 → `result_valid` in cycle 6, `result` = 123.
- **Three beats, back to back.** N=3, bias 3.
  - Beats: lanes 0..15, then all 10, then lanes {1,1,1,1,11,11,11,11} repeated twice.
  - Per-beat tree sums: 123, 160, 96.
  - Required: `result` = 379 in cycle 8; `in_ready` low from cycle 4.
- **Bubbles.** Same three beats with `in_valid` low in cycles 2 and 4.
  - Required: `result` = 379 in cycle 10; `tree_last_in` = 3 only in the first fire cycle and 0 elsewhere, including bubble cycles.
- **Wrap.** N=2, all lanes 255, bias 0.
  - Each beat's tree sum is 240; required `result` = 480.
  - Repeat with N=255 of those beats and `ACC_W`=16: required `result` = 61200.
- **Handshake and edge cases.**
  - `result_ready` low for 5 cycles → `result` stable, `busy` = 1.
  - A `start` pulse during FEED is ignored.
  - N=0 → `result` = 0 in cycle 1.
- **Reset mid-job.** Assert `rst_n` low in cycle 3 of an N=3 job.
  - Required: all outputs take reset values immediately.
  - After release, a new N=1 job (lanes 0..15, bias 3) returns 123 with no stale contribution.

Source files
------------

// File: rtl/adder_tree_sequencer.sv
// adder_tree_sequencer: feeds beats into a fixed-latency adder tree and accumulates its outputs per job
module adder_tree_sequencer #(
   parameter int WIDTH    = 8,
   parameter int ACC_W    = 16,
   parameter int TREE_LAT = 4,
   parameter int CNT_W    = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [CNT_W-1:0]    num_beats,
   input  logic [WIDTH-1:0]    bias,
   output logic                busy,
   input  logic                in_valid,
   input  logic [16*WIDTH-1:0] in_data,
   output logic                in_ready,
   output logic [16*WIDTH-1:0] tree_inputs,
   output logic [WIDTH-1:0]    tree_last_in,
   input  logic [WIDTH-1:0]    tree_out,
   output logic [ACC_W-1:0]    result,
   output logic                result_valid,
   input  logic                result_ready
);
   typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;
   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0]    bias_q, bias_d;
   logic                first_q, first_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [TREE_LAT-1:0] vld_q, vld_d;
   logic                fire;
   assign fire         = in_valid && state_q == FEED;
   assign in_ready     = state_q == FEED;
   assign busy         = state_q != IDLE;
   assign result_valid = state_q == DONE;
   assign result       = acc_q;
   assign tree_inputs  = fire ? in_data : '0;
   assign tree_last_in = (fire && first_q) ? bias_q : '0;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bias_d  = bias_q;
      first_d = first_q;
      vld_d   = (vld_q << 1) | TREE_LAT'(fire);
      acc_d   = vld_q[TREE_LAT-1] ? acc_q + ACC_W'(tree_out) : acc_q;
      case (state_q)
         IDLE: if (start) begin
            acc_d   = '0;
            cnt_d   = num_beats;
            bias_d  = bias;
            first_d = 1'b1;
            state_d = num_beats != '0 ? FEED : DONE;
         end
         FEED: if (fire) begin
            cnt_d   = cnt_q - CNT_W'(1);
            first_d = 1'b0;
            state_d = cnt_q == CNT_W'(1) ? DRAIN : FEED;
         end
         // the last beat is leaving the tree once it is the only one in flight
         DRAIN: state_d = vld_q == (TREE_LAT'(1) << (TREE_LAT-1)) ? DONE : DRAIN;
         DONE:  state_d = result_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bias_q  <= '0;
         first_q <= 1'b0;
         acc_q   <= '0;
         vld_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bias_q  <= bias_d;
         first_q <= first_d;
         acc_q   <= acc_d;
         vld_q   <= vld_d;
      end
   end
endmodule

// File: tb/tb_adder_tree_sequencer.sv
// tb_adder_tree_sequencer: directed tests with a behavioural 4-stage adder tree model
module tb_adder_tree_sequencer;
   localparam int W = 8, A = 16, L = 4, C = 8;
   logic              clk = 1'b0, rst_n = 1'b1, start = 1'b0, in_valid = 1'b0, result_ready = 1'b1;
   logic [C-1:0]      num_beats = '0;
   logic [W-1:0]      bias = '0;
   logic [16*W-1:0]   in_data = '0;
   logic              busy, in_ready, result_valid;
   logic [16*W-1:0]   tree_inputs;
   logic [W-1:0]      tree_last_in, tree_out, tsum;
   logic [A-1:0]      result;
   logic [W-1:0]      tp [0:L-1];
   logic [16*W-1:0]   beat_mem [0:255];
   int                checks = 0, errors = 0;

   adder_tree_sequencer #(.WIDTH(W), .ACC_W(A), .TREE_LAT(L), .CNT_W(C)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_beats(num_beats), .bias(bias),
      .busy(busy), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .tree_inputs(tree_inputs), .tree_last_in(tree_last_in), .tree_out(tree_out),
      .result(result), .result_valid(result_valid), .result_ready(result_ready)
   );

   always #5 clk = ~clk;

   // unreset tree model: sum wraps to W bits, valid L edges after inputs
   always_comb begin
      tsum = tree_last_in;
      for (int l = 0; l < 16; l++) tsum = tsum + tree_inputs[l*W +: W];
   end
   always @(posedge clk) begin
      tp[0] <= tsum;
      for (int i = 1; i < L; i++) tp[i] <= tp[i-1];
   end
   assign tree_out = tp[L-1];

   task automatic set_beat(input int i, input int kind);
      logic [W-1:0] pat [0:7];
      pat = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd11, 8'd11, 8'd11, 8'd11};
      for (int l = 0; l < 16; l++)
         beat_mem[i][l*W +: W] = kind == 0 ? W'(l) : kind == 1 ? 8'd10 : kind == 2 ? pat[l%8] : 8'd255;
   endtask

   task automatic run_job(input int n, input logic [W-1:0] b, input logic [31:0] gaps, input int sp,
                          output logic [A-1:0] res, output int rcyc, output int bad, output int rdy_low);
      int idx = 0, c = 1;
      logic f;
      rcyc = -1; bad = 0; rdy_low = -1; res = '0;
      start = 1'b1; num_beats = C'(n); bias = b;
      @(posedge clk); #1;
      start = 1'b0;
      while (c < 700) begin
         start = (c == sp);
         if (c == sp) num_beats = '0;
         in_valid = (idx < n) && !(c < 32 && gaps[c]);
         in_data = beat_mem[idx % 256];
         @(negedge clk);
         f = in_valid && in_ready;
         if (in_ready !== (idx < n)) bad++;
         if (tree_last_in !== ((f && idx == 0) ? b : '0)) bad++;
         if (tree_inputs !== (f ? in_data : '0)) bad++;
         if (!in_ready && rdy_low < 0) rdy_low = c;
         if (result_valid) begin
            res = result; rcyc = c;
            break;
         end
         @(posedge clk); #1;
         if (f) idx++;
         c++;
      end
      in_valid = 1'b0; start = 1'b0;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      @(posedge clk); @(negedge clk);
      checks += 6;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
      if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b want 0", in_ready); end
      if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_result_valid got %0b want 0", result_valid); end
      if (result !== '0) begin errors++; $display("FAIL reset_result got %0d want 0", result); end
      if (tree_inputs !== '0) begin errors++; $display("FAIL reset_tree_inputs got %h want 0", tree_inputs); end
      if (tree_last_in !== '0) begin errors++; $display("FAIL reset_tree_last_in got %0d want 0", tree_last_in); end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      logic [A-1:0] r; int rc, bad, rl;
      set_beat(0, 0);
      result_ready = 1'b1;
      run_job(1, 8'd3, 0, 0, r, rc, bad, rl);
      checks += 3;
      if (r !== 16'd123) begin errors++; $display("FAIL single_result got %0d want 123", r); end
      if (rc !== 6) begin errors++; $display("FAIL single_cycle got %0d want 6", rc); end
      if (bad !== 0) begin errors++; $display("FAIL single_drive got %0d bad cycles want 0", bad); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (result_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL single_release got valid %0b busy %0b want 0 0", result_valid, busy);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic [A-1:0] r; int rc, bad, rl;
      set_beat(0, 0); set_beat(1, 1); set_beat(2, 2);
      run_job(3, 8'd3, 0, 0, r, rc, bad, rl);
      checks += 4;
      if (r !== 16'd379) begin errors++; $display("FAIL b2b_result got %0d want 379", r); end
      if (rc !== 8) begin errors++; $display("FAIL b2b_cycle got %0d want 8", rc); end
      if (rl !== 4) begin errors++; $display("FAIL b2b_ready_low got %0d want 4", rl); end
      if (bad !== 0) begin errors++; $display("FAIL b2b_drive got %0d bad cycles want 0", bad); end
      @(posedge clk); #1;
   endtask

   task automatic test_bubbles();
      logic [A-1:0] r; int rc, bad, rl;
      run_job(3, 8'd3, 32'h14, 0, r, rc, bad, rl);
      checks += 4;
      if (r !== 16'd379) begin errors++; $display("FAIL bubble_result got %0d want 379", r); end
      if (rc !== 10) begin errors++; $display("FAIL bubble_cycle got %0d want 10", rc); end
      if (rl !== 6) begin errors++; $display("FAIL bubble_ready_low got %0d want 6", rl); end
      if (bad !== 0) begin errors++; $display("FAIL bubble_drive got %0d bad cycles want 0", bad); end
      @(posedge clk); #1;
   endtask

   task automatic test_start_ignored();
      logic [A-1:0] r; int rc, bad, rl;
      run_job(3, 8'd3, 0, 2, r, rc, bad, rl);
      checks += 2;
      if (r !== 16'd379) begin errors++; $display("FAIL feed_start_result got %0d want 379", r); end
      if (rc !== 8) begin errors++; $display("FAIL feed_start_cycle got %0d want 8", rc); end
      @(posedge clk); #1;
   endtask

   task automatic test_handshake();
      logic [A-1:0] r; int rc, bad, rl;
      result_ready = 1'b0;
      run_job(1, 8'd3, 0, 0, r, rc, bad, rl);
      checks++;
      if (r !== 16'd123) begin errors++; $display("FAIL hold_result got %0d want 123", r); end
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         checks++;
         if (result_valid !== 1'b1 || busy !== 1'b1 || result !== 16'd123) begin
            errors++;
            $display("FAIL hold_stable got valid %0b busy %0b result %0d want 1 1 123", result_valid, busy, result);
         end
      end
      @(posedge clk); #1;
      result_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (result_valid !== 1'b1) begin errors++; $display("FAIL hold_accept got %0b want 1", result_valid); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (result_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL hold_release got valid %0b busy %0b want 0 0", result_valid, busy);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_zero();
      logic [A-1:0] r; int rc, bad, rl;
      run_job(0, 8'd7, 0, 0, r, rc, bad, rl);
      checks += 2;
      if (r !== '0) begin errors++; $display("FAIL zero_result got %0d want 0", r); end
      if (rc !== 1) begin errors++; $display("FAIL zero_cycle got %0d want 1", rc); end
      @(posedge clk); #1;
   endtask

   task automatic test_wrap();
      logic [A-1:0] r; int rc, bad, rl;
      for (int i = 0; i < 256; i++) set_beat(i, 3);
      run_job(2, 8'd0, 0, 0, r, rc, bad, rl);
      checks += 2;
      if (r !== 16'd480) begin errors++; $display("FAIL wrap2_result got %0d want 480", r); end
      if (rc !== 7) begin errors++; $display("FAIL wrap2_cycle got %0d want 7", rc); end
      @(posedge clk); #1;
      run_job(255, 8'd0, 0, 0, r, rc, bad, rl);
      checks += 3;
      if (r !== 16'd61200) begin errors++; $display("FAIL wrap255_result got %0d want 61200", r); end
      if (rc !== 260) begin errors++; $display("FAIL wrap255_cycle got %0d want 260", rc); end
      if (bad !== 0) begin errors++; $display("FAIL wrap255_drive got %0d bad cycles want 0", bad); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      logic [A-1:0] r; int rc, bad, rl;
      set_beat(0, 0); set_beat(1, 1); set_beat(2, 2);
      start = 1'b1; num_beats = 8'd3; bias = 8'd3;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1; in_data = beat_mem[k];
         if (k < 2) begin @(posedge clk); #1; end
      end
      #2 rst_n = 1'b0;
      #1;
      checks += 3;
      if (busy !== 1'b0 || in_ready !== 1'b0 || result_valid !== 1'b0) begin
         errors++; $display("FAIL midrst_flags got busy %0b ready %0b valid %0b want 0 0 0", busy, in_ready, result_valid);
      end
      if (result !== '0) begin errors++; $display("FAIL midrst_result got %0d want 0", result); end
      if (tree_inputs !== '0 || tree_last_in !== '0) begin
         errors++; $display("FAIL midrst_tree got %h %0d want 0 0", tree_inputs, tree_last_in);
      end
      in_valid = 1'b0;
      @(posedge clk); @(posedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      set_beat(0, 0);
      run_job(1, 8'd3, 0, 0, r, rc, bad, rl);
      checks += 2;
      if (r !== 16'd123) begin errors++; $display("FAIL midrst_after_result got %0d want 123", r); end
      if (rc !== 6) begin errors++; $display("FAIL midrst_after_cycle got %0d want 6", rc); end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_bubbles();
      test_start_ignored();
      test_handshake();
      test_zero();
      test_wrap();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
